// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcode/function constants, field positions,
// the decoded bundle type and the R-type legality check.
package rv_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

  localparam logic [2:0] FUNC3_ADD = 3'b000;
  localparam logic [2:0] FUNC3_XOR = 3'b100;
  localparam logic [2:0] FUNC3_OR  = 3'b110;
  localparam logic [2:0] FUNC3_AND = 3'b111;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } bundle_t;

  function automatic logic is_legal(input logic [6:0] opc, input logic [6:0] f7,
                                    input logic [2:0] f3);
    logic base_ok;
    logic alt_ok;
    base_ok = (f7 == FUNC7_BASE) &&
              ((f3 == FUNC3_ADD) || (f3 == FUNC3_XOR) ||
               (f3 == FUNC3_OR)  || (f3 == FUNC3_AND));
    alt_ok  = (f7 == FUNC7_ALT) && (f3 == FUNC3_ADD);
    return (opc == OPC_RTYPE) && (base_ok || alt_ok);
  endfunction

  function automatic bundle_t decode(input logic [31:0] instr);
    bundle_t b;
    b.opcode  = instr[OPC_LSB +: 7];
    b.func3   = instr[F3_LSB  +: 3];
    b.func7   = instr[F7_LSB  +: 7];
    b.rd      = instr[RD_LSB  +: 5];
    b.rs1     = instr[RS1_LSB +: 5];
    b.rs2     = instr[RS2_LSB +: 5];
    b.illegal = !is_legal(b.opcode, b.func7, b.func3);
    return b;
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// NREGS x XLEN register file: two async read ports with write-read bypass, one write port.
// x0 reads zero and ignores writes; whole array cleared by async reset.
module rv_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // A write landing this edge is forwarded so the reader sees the new value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : mem[ra2];
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: slices fields, reads operands, one-entry output register (1-cycle latency).
// in_ready = !out_valid || out_ready; a stalled bundle is patched by matching writebacks.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       OPCODE,
  output logic [2:0]       FUNC3,
  output logic [6:0]       FUNC7,
  output logic [XLEN-1:0]  OP1,
  output logic [XLEN-1:0]  OP2,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] instr_count
);

  bundle_t          dec;
  bundle_t          held;
  logic [XLEN-1:0]  rf_rd1;
  logic [XLEN-1:0]  rf_rd2;
  logic [XLEN-1:0]  op1_q;
  logic [XLEN-1:0]  op2_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             wb_hit;

  assign dec      = decode(in_instr);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_hit   = wb_en && (wb_rd != 5'd0);

  rv_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wb_en),
    .wa    (wb_rd),
    .wd    (wb_data),
    .ra1   (dec.rs1),
    .ra2   (dec.rs2),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      held    <= dec;
      op1_q   <= rf_rd1;
      op2_q   <= rf_rd2;
      valid_q <= 1'b1;
      cnt_q   <= cnt_q + CNT_W'(1);
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end else if (valid_q && wb_hit) begin
      // Held operands track writebacks so the bundle is current when it drains.
      if (wb_rd == held.rs1) op1_q <= wb_data;
      if (wb_rd == held.rs2) op2_q <= wb_data;
    end
  end

  assign out_valid   = valid_q;
  assign OPCODE      = held.opcode;
  assign FUNC3       = held.func3;
  assign FUNC7       = held.func7;
  assign out_rd      = held.rd;
  assign out_illegal = held.illegal;
  assign OP1         = op1_q;
  assign OP2         = op2_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: reference register-file model and an expected-bundle queue.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNC3;
  logic [6:0]  FUNC7;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  rv_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .OPCODE(OPCODE), .FUNC3(FUNC3), .FUNC7(FUNC7), .OP1(OP1), .OP2(OP2),
    .out_rd(out_rd), .out_illegal(out_illegal), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .instr_count(instr_count)
  );

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        ill;
  } vec_t;

  exp_t        q[$];
  logic [31:0] ref_rf[32];
  logic [31:0] cnt_m;
  int          n_chk;
  int          n_fail;
  vec_t        vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check the state left by the previous edge, update the model.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic ill);
    exp_t e;
    logic acc;
    @(negedge clk);
    in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, (q.size() == 0) || ordy);
    chk("instr_count", instr_count, cnt_m);
    acc = iv && ((q.size() == 0) || ordy);
    if (q.size() != 0) begin
      e = q[0];
      if (ordy) begin
        chk("OPCODE", OPCODE, e.opcode);
        chk("FUNC3", FUNC3, e.f3);
        chk("FUNC7", FUNC7, e.f7);
        chk("OP1", OP1, e.op1);
        chk("OP2", OP2, e.op2);
        chk("out_rd", out_rd, e.rd);
        chk("out_illegal", out_illegal, e.ill);
        void'(q.pop_front());
      end else if (we && wrd != 5'd0) begin
        if (e.rs1 == wrd) e.op1 = wd;
        if (e.rs2 == wrd) e.op2 = wd;
        q[0] = e;
      end
    end
    if (acc) begin
      e.opcode = ins[6:0];
      e.f3     = ins[14:12];
      e.f7     = ins[31:25];
      e.rd     = ins[11:7];
      e.rs1    = ins[19:15];
      e.rs2    = ins[24:20];
      e.ill    = ill;
      e.op1    = (e.rs1 == 5'd0) ? 32'd0 : (we && wrd == e.rs1) ? wd : ref_rf[e.rs1];
      e.op2    = (e.rs2 == 5'd0) ? 32'd0 : (we && wrd == e.rs2) ? wd : ref_rf[e.rs2];
      q.push_back(e);
      cnt_m++;
    end
    if (we && wrd != 5'd0) ref_rf[wrd] = wd;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    cnt_m = 32'd0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    model_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;

    vt[0] = '{32'h00208093, 1'b1, 5'd2, 32'h11,       1'b1};  // addi
    vt[1] = '{32'h0020F0B3, 1'b0, 5'd0, 32'h0,        1'b0};  // and
    vt[2] = '{32'h0020E0B3, 1'b1, 5'd1, 32'hA5A5A5A5, 1'b0};  // or, bypass rs1
    vt[3] = '{32'h0020C0B3, 1'b0, 5'd0, 32'h0,        1'b0};  // xor
    vt[4] = '{32'h4020F0B3, 1'b0, 5'd0, 32'h0,        1'b1};  // alt func7 with and func3
    vt[5] = '{32'h022080B3, 1'b1, 5'd7, 32'h77,       1'b1};  // mul encoding
    vt[6] = '{32'h002090B3, 1'b0, 5'd0, 32'h0,        1'b1};  // sll
    vt[7] = '{32'h000000B7, 1'b0, 5'd0, 32'h0,        1'b1};  // lui

    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst instr_count", instr_count, 0);
    chk("rst OPCODE", OPCODE, 0);
    chk("rst OP1", OP1, 0);
    chk("rst out_illegal", out_illegal, 0);
    @(negedge clk); rst_n = 1'b1;

    cycle(0, 32'h0, 1, 1, 5'd1, 32'd5, 0);
    cycle(0, 32'h0, 1, 1, 5'd2, 32'd3, 0);
    cycle(1, 32'h002080B3, 1, 0, 5'd0, 32'd0, 0);       // add x1,x1,x2
    cycle(1, 32'h402080B3, 1, 1, 5'd2, 32'd9, 0);       // sub with bypass on x2
    chk("add OP1", OP1, 5);
    chk("add OP2", OP2, 3);
    chk("add out_rd", out_rd, 1);
    chk("add count", instr_count, 1);
    cycle(1, 32'h002101B3, 1, 0, 5'd0, 32'd0, 0);       // add x3,x2,x2
    chk("sub OP2 bypass", OP2, 9);
    chk("sub FUNC7", FUNC7, 7'b0100000);
    cycle(1, 32'h002080B3, 1, 0, 5'd0, 32'd0, 0);
    chk("x2 readback", OP1, 9);

    cycle(1, 32'h0020E0B3, 0, 1, 5'd1, 32'hDEADBEEF, 0); // stalled, x1 written
    cycle(0, 32'h0, 0, 0, 5'd0, 32'd0, 0);
    chk("stall OP1 patch", OP1, 32'hDEADBEEF);
    chk("stall in_ready", in_ready, 0);
    chk("stall count", instr_count, 4);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'd0, 0);

    cycle(1, 32'h00528233, 1, 1, 5'd5, 32'd77, 0);      // add x4,x5,x5 with bypass on both
    cycle(0, 32'h0, 1, 1, 5'd0, 32'h1234, 0);
    chk("rs1=rs2 OP1", OP1, 77);
    chk("rs1=rs2 OP2", OP2, 77);
    cycle(1, 32'h002000B3, 1, 0, 5'd0, 32'd0, 0);       // add x1,x0,x2
    cycle(0, 32'h0, 1, 0, 5'd0, 32'd0, 0);
    chk("x0 OP1", OP1, 0);

    for (int i = 0; i < 8; i++)
      cycle(1, vt[i].instr, 1, vt[i].we, vt[i].wrd, vt[i].wd, vt[i].ill);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'd0, 0);

    for (int i = 0; i < 4; i++)
      cycle(1, vt[i].instr, 1, 1, 5'(i + 8), 32'(i * 3 + 1), vt[i].ill);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async instr_count", instr_count, 0);
    chk("async OP1", OP1, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    cycle(1, 32'h002081B3, 1, 0, 5'd0, 32'd0, 0);       // add x3,x1,x2
    cycle(1, 32'h00A48433, 1, 0, 5'd0, 32'd0, 0);       // add x8,x9,x10
    chk("post-rst OP1", OP1, 0);
    chk("post-rst OP2", OP2, 0);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'd0, 0);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'd0, 0);
    chk("queue drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
